// File: rtl/sysa_pkg.sv
`default_nettype none
// ============================================================================
//  Module : sysa_pkg
//  Brief  : Shared defaults, feeder state encoding and drain-length helper
//           for the systolic-array feeder.
//  Rev    : 1.0  initial release
// ============================================================================
package sysa_pkg;

  localparam int N_DEF  = 3;   // array dimension
  localparam int DW_DEF = 8;   // activation element width
  localparam int ACC_W  = 16;  // array result width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } feed_state_t;

  // Zero-injection cycles needed to flush the last vector through an N x N array.
  function automatic int drain_len(input int n);
    return 2 * n - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sysa_skew_lane.sv
`default_nettype none
// ============================================================================
//  Module : sysa_skew_lane
//  Brief  : Enable-gated delay line of STAGES registers; one array row's skew.
//  Rev    : 1.0  initial release
// ============================================================================
module sysa_skew_lane #(
  parameter int DW     = 8,
  parameter int STAGES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_stage [STAGES];

  // Shift the whole chain by one position on each enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sysa_feeder.sv
`default_nettype none
// ============================================================================
//  Module : sysa_feeder
//  Brief  : Upstream feeder for an N x N systolic array. Buffers activation
//           vectors in a FIFO, skews lane k by k cycles, and injects zeros
//           after the last vector of a batch until the array has drained.
//  Config : SYSA_FEED_PERF_EN adds the 16-bit stall_cnt output.
//  Rev    : 1.0  initial release
// ============================================================================
module sysa_feeder
  import sysa_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW*N-1:0] s_data,
  input  logic            s_last,
  output logic [DW*N-1:0] arr_in,
  output logic            arr_en,
  output logic            busy,
  output logic            done
`ifdef SYSA_FEED_PERF_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(2 * N);  // wide enough to hold 2N-1
  localparam logic [CW-1:0] c_DRAIN_LEN = CW'(drain_len(N));
  localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);

  // ---------------------------------------------------------------- FIFO
  logic [DW*N:0]   r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [DW*N:0]   w_head;
  logic            w_head_last;
  logic [DW*N-1:0] w_head_data;

  feed_state_t     r_state;
  feed_state_t     w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_adv;
  logic            r_arr_en;
  logic [DW*N-1:0] w_lane_d;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign w_push      = s_valid && !w_full;
  assign w_pop       = w_adv && (r_state == ST_STREAM);
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_last = w_head[DW*N];
  assign w_head_data = w_head[DW*N-1:0];

  // Store {last, data} at the write pointer; storage needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {s_last, s_data};
  end

  // Advance the FIFO pointers on accepted pushes and pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ------------------------------------------------------------ control
  // The skew chain and the array move together: one shift per adv cycle.
  assign w_adv = ((r_state == ST_STREAM) && !w_empty) || (r_state == ST_DRAIN);

  // Hold the state and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: stream until the last entry pops, then flush 2N-1 zeros.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (w_pop && w_head_last) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = c_DRAIN_LEN;
        end
      end
      ST_DRAIN: begin
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register the enable so it lines up with the shifted arr_in value.
  always_ff @(posedge clk) begin
    if (rst) r_arr_en <= 1'b0;
    else     r_arr_en <= w_adv;
  end

  assign w_lane_d = (r_state == ST_STREAM) ? w_head_data : '0;
  assign arr_en   = r_arr_en;
  assign s_ready  = !w_full;
  assign busy     = (r_state != ST_IDLE) || !w_empty;
  assign done     = (r_state == ST_DONE);

  // ------------------------------------------------------------- skew
  for (genvar k = 0; k < N; k++) begin : g_lane
    sysa_skew_lane #(
      .DW     (DW),
      .STAGES (k + 1)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .i_en (w_adv),
      .i_d  (w_lane_d[DW*k +: DW]),
      .o_q  (arr_in[DW*k +: DW])
    );
  end

`ifdef SYSA_FEED_PERF_EN
  logic [15:0] r_stall_cnt;

  // Count STREAM cycles starved by an empty FIFO; restart at each batch start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_STREAM)) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_STREAM) && w_empty && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
